// File: rtl/wb_initiator_bridge.sv
// Wishbone classic initiator bridge: turns a valid/ready command into a single
// read or write bus cycle and returns the outcome on a valid/ready response channel.
module wb_initiator_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_adr,
  input  logic                    req_we,
  input  logic [DATA_WIDTH-1:0]   req_dat,
  input  logic [DATA_WIDTH/8-1:0] req_sel,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_dat,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   it_adr,
  output logic [DATA_WIDTH-1:0]   it_dat_w,
  input  logic [DATA_WIDTH-1:0]   it_dat_r,
  output logic                    it_cyc,
  output logic                    it_stb,
  output logic                    it_we,
  output logic [DATA_WIDTH/8-1:0] it_sel,
  input  logic                    it_ack,
  input  logic                    it_err
);

  localparam int SW = DATA_WIDTH / 8;
  // A zero TIMEOUT still needs a legal one-bit counter; the compare is gated off.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0] adr_reg, adr_next;
  logic [DATA_WIDTH-1:0] dat_w_reg, dat_w_next;
  logic [SW-1:0]       sel_reg, sel_next;
  logic                we_reg, we_next;
  logic                cyc_reg, cyc_next;
  logic [DATA_WIDTH-1:0] rsp_dat_reg, rsp_dat_next;
  logic                rsp_err_reg, rsp_err_next;
  logic                rsp_to_reg, rsp_to_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      adr_reg     <= '0;
      dat_w_reg   <= '0;
      sel_reg     <= '0;
      we_reg      <= 1'b0;
      cyc_reg     <= 1'b0;
      rsp_dat_reg <= '0;
      rsp_err_reg <= 1'b0;
      rsp_to_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      adr_reg     <= adr_next;
      dat_w_reg   <= dat_w_next;
      sel_reg     <= sel_next;
      we_reg      <= we_next;
      cyc_reg     <= cyc_next;
      rsp_dat_reg <= rsp_dat_next;
      rsp_err_reg <= rsp_err_next;
      rsp_to_reg  <= rsp_to_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    adr_next     = adr_reg;
    dat_w_next   = dat_w_reg;
    sel_next     = sel_reg;
    we_next      = we_reg;
    cyc_next     = cyc_reg;
    rsp_dat_next = rsp_dat_reg;
    rsp_err_next = rsp_err_reg;
    rsp_to_next  = rsp_to_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          adr_next   = req_adr;
          dat_w_next = req_dat;
          sel_next   = req_sel;
          we_next    = req_we;
          cyc_next   = 1'b1;
          cnt_next   = '0;
          state_next = BUS;
        end
      end
      BUS: begin
        // Priority: err beats ack, and either beats a timeout on the same cycle.
        if (it_err) begin
          cyc_next     = 1'b0;
          rsp_dat_next = '0;
          rsp_err_next = 1'b1;
          rsp_to_next  = 1'b0;
          state_next   = RSP;
        end else if (it_ack) begin
          cyc_next     = 1'b0;
          rsp_dat_next = we_reg ? '0 : it_dat_r;
          rsp_err_next = 1'b0;
          rsp_to_next  = 1'b0;
          state_next   = RSP;
        end else if ((TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
          cyc_next     = 1'b0;
          rsp_dat_next = '0;
          rsp_err_next = 1'b1;
          rsp_to_next  = 1'b1;
          state_next   = RSP;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RSP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready   = (state_reg == IDLE);
  assign rsp_valid   = (state_reg == RSP);
  assign rsp_dat     = rsp_dat_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_timeout = rsp_to_reg;
  assign it_adr      = adr_reg;
  assign it_dat_w    = dat_w_reg;
  assign it_sel      = sel_reg;
  assign it_we       = we_reg;
  assign it_cyc      = cyc_reg;
  assign it_stb      = cyc_reg;

endmodule

// File: tb/tb_wb_initiator_bridge.sv
// Directed bench for wb_initiator_bridge: a scripted Wishbone target plus a
// response scoreboard queue filled at issue time and drained when rsp_valid appears.
module tb_wb_initiator_bridge;

  localparam int TO = 4;

  logic        clock, reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_dat;
  logic [31:0] it_adr, it_dat_w, it_dat_r;
  logic        it_cyc, it_stb, it_we, it_ack, it_err;
  logic [3:0]  it_sel;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic        to;
  } rsp_t;
  rsp_t exp_q[$];

  wb_initiator_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_adr(req_adr),
    .req_we(req_we), .req_dat(req_dat), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .it_adr(it_adr), .it_dat_w(it_dat_w), .it_dat_r(it_dat_r),
    .it_cyc(it_cyc), .it_stb(it_stb), .it_we(it_we), .it_sel(it_sel),
    .it_ack(it_ack), .it_err(it_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present a request and return at the first negedge after it was accepted.
  task automatic issue(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                       input logic [3:0] sel);
    int n;
    req_adr = adr; req_we = we; req_dat = dat; req_sel = sel; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("req_ready_pre_accept", req_ready, 1);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // mode: 0 ack, 1 err, 2 ack+err, 3 silent. Target answers on cyc cycle ack_after+1.
  task automatic bus(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                     input logic [3:0] sel, input int ack_after, input int mode,
                     input logic [31:0] rdat, input int exp_cycles);
    rsp_t e, got;
    int   cycles;
    bit   done;
    if (mode == 3)      e = '{dat: 32'h0, err: 1'b1, to: 1'b1};
    else if (mode != 0) e = '{dat: 32'h0, err: 1'b1, to: 1'b0};
    else                e = '{dat: (we ? 32'h0 : rdat), err: 1'b0, to: 1'b0};
    exp_q.push_back(e);
    cycles = 0;
    done   = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (it_cyc) begin
        cycles++;
        check("it_stb", it_stb, 1);
        check("it_adr", it_adr, adr);
        check("it_we", it_we, we);
        check("it_dat_w", it_dat_w, wdat);
        check("it_sel", it_sel, sel);
        check("req_ready_in_bus", req_ready, 0);
        check("rsp_valid_in_bus", rsp_valid, 0);
        it_dat_r = rdat;
        it_ack = (mode == 0 || mode == 2) && (cycles == ack_after + 1);
        it_err = (mode == 1 || mode == 2) && (cycles == ack_after + 1);
        @(negedge clock);
        it_ack = 1'b0;
        it_err = 1'b0;
        it_dat_r = 32'hFFFF_0000;
      end else begin
        done = 1'b1;
      end
    end
    check("cyc_cycles", cycles, exp_cycles);
    check("rsp_valid_after_bus", rsp_valid, 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      got = exp_q.pop_front();
      check("rsp_dat", rsp_dat, got.dat);
      check("rsp_err", rsp_err, got.err);
      check("rsp_timeout", rsp_timeout, got.to);
    end
  endtask

  task automatic finish_rsp(input int hold);
    logic [31:0] d;
    logic        er, t;
    d = rsp_dat; er = rsp_err; t = rsp_timeout;
    repeat (hold) begin
      @(negedge clock);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_fields", {rsp_dat, rsp_err, rsp_timeout}, {d, er, t});
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
    check("req_ready_back", req_ready, 1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_adr = '0; req_we = 1'b0; req_dat = '0;
    req_sel = '0; rsp_ready = 1'b0; it_dat_r = '0; it_ack = 1'b0; it_err = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_it_cyc", it_cyc, 0);
    check("rst_it_stb", it_stb, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_outputs", {it_adr, it_dat_w, it_sel, it_we, rsp_dat, rsp_err, rsp_timeout}, 0);
    reset = 1'b0;
    @(negedge clock);

    // Write acked in its first bus cycle
    issue(32'h4, 1'b1, 32'hDEADBEEF, 4'hF);
    bus(32'h4, 1'b1, 32'hDEADBEEF, 4'hF, 0, 0, 32'hCAFEF00D, 1);
    finish_rsp(0);

    // Read with three wait states
    issue(32'h8, 1'b0, 32'h0, 4'hF);
    bus(32'h8, 1'b0, 32'h0, 4'hF, 3, 0, 32'h12345678, 4);
    finish_rsp(1);

    // Bus error, then ack and err together
    issue(32'h10, 1'b0, 32'h0, 4'h1);
    bus(32'h10, 1'b0, 32'h0, 4'h1, 1, 1, 32'h55AA55AA, 2);
    finish_rsp(0);
    issue(32'h14, 1'b1, 32'h01020304, 4'hC);
    bus(32'h14, 1'b1, 32'h01020304, 4'hC, 0, 2, 32'h55AA55AA, 1);
    finish_rsp(0);

    // Silent target times out; ack on the last allowed cycle still wins
    issue(32'h20, 1'b0, 32'h0, 4'hF);
    bus(32'h20, 1'b0, 32'h0, 4'hF, 0, 3, 32'h9999_9999, TO);
    finish_rsp(0);
    issue(32'h24, 1'b0, 32'h0, 4'hF);
    bus(32'h24, 1'b0, 32'h0, 4'hF, TO - 1, 0, 32'hA5A5C3C3, TO);
    finish_rsp(0);

    // Response backpressure with a second request waiting
    issue(32'h30, 1'b0, 32'h0, 4'hF);
    bus(32'h30, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0BADCAFE, 1);
    req_adr = 32'h34; req_we = 1'b1; req_dat = 32'h11223344; req_sel = 4'h3; req_valid = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("bp_req_ready", req_ready, 0);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_dat", rsp_dat, 32'h0BADCAFE);
      check("bp_it_cyc", it_cyc, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("bp_rsp_drop", rsp_valid, 0);
    check("bp_req_ready_after", req_ready, 1);
    issue(32'h34, 1'b1, 32'h11223344, 4'h3);
    bus(32'h34, 1'b1, 32'h11223344, 4'h3, 0, 0, 32'h0, 1);
    finish_rsp(0);

    // Reset while in BUS, then a late ack must be ignored
    issue(32'h40, 1'b0, 32'h0, 4'hF);
    check("rb_cyc_up", it_cyc, 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rb_it_cyc", it_cyc, 0);
    check("rb_it_stb", it_stb, 0);
    check("rb_rsp_valid", rsp_valid, 0);
    check("rb_req_ready", req_ready, 1);
    check("rb_it_adr", it_adr, 0);
    it_ack = 1'b1; it_dat_r = 32'h13572468;
    @(negedge clock);
    it_ack = 1'b0;
    check("rb_late_ack_rsp", rsp_valid, 0);
    check("rb_late_ack_cyc", it_cyc, 0);

    // Reset while in RSP discards the pending response
    issue(32'h44, 1'b0, 32'h0, 4'hF);
    bus(32'h44, 1'b0, 32'h0, 4'hF, 0, 0, 32'h00000077, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rr_rsp_valid", rsp_valid, 0);
    check("rr_req_ready", req_ready, 1);
    check("rr_rsp_fields", {rsp_dat, rsp_err, rsp_timeout}, 0);
    it_ack = 1'b1;
    @(negedge clock);
    it_ack = 1'b0;
    check("rr_late_ack_rsp", rsp_valid, 0);

    // Normal operation resumes after reset
    issue(32'h50, 1'b1, 32'hFEEDFACE, 4'h6);
    bus(32'h50, 1'b1, 32'hFEEDFACE, 4'h6, 2, 0, 32'h0, 3);
    finish_rsp(0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_initiator_bridge.md
Name: wb_initiator_bridge

Overview:
- Wishbone classic initiator: converts a valid/ready command channel into single Wishbone read/write cycles and returns results on a valid/ready response channel.
- Lets firmware-side sequencers and test engines drive Wishbone targets such as the interrupt controller and timers.
- One transaction outstanding; bus timeout guards against a target that never acknowledges.

Parameters:
ADDR_WIDTH, 32, width of request address and bus address
DATA_WIDTH, 32, width of write and read data; must be a multiple of 8
TIMEOUT, 255, cycles to wait for ack/err before forcing an error response; 0 disables the timeout

Ports:
clock  input  1  clock; all logic on its rising edge
reset  input  1  synchronous active-high reset
req_valid  input  1  command present
req_ready  output  1  bridge accepts command this cycle
req_adr  input  ADDR_WIDTH  byte address
req_we  input  1  1=write, 0=read
req_dat  input  DATA_WIDTH  write data
req_sel  input  DATA_WIDTH/8  byte lane enables
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_dat  output  DATA_WIDTH  read data (0 for writes and errors)
rsp_err  output  1  1=bus error or timeout
rsp_timeout  output  1  1=error caused by timeout
it_adr  output  ADDR_WIDTH  Wishbone address
it_dat_w  output  DATA_WIDTH  Wishbone write data
it_dat_r  input  DATA_WIDTH  Wishbone read data
it_cyc  output  1  Wishbone cycle
it_stb  output  1  Wishbone strobe
it_we  output  1  Wishbone write enable
it_sel  output  DATA_WIDTH/8  Wishbone byte select
it_ack  input  1  Wishbone acknowledge
it_err  input  1  Wishbone error

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous and active-high.
- Reset: state=IDLE. it_cyc, it_stb, it_we, rsp_valid, rsp_err and rsp_timeout are 0. it_adr, it_dat_w, it_sel and rsp_dat are 0. Timeout counter is 0.
- FSM states: IDLE, BUS, RSP.
- IDLE:
  - req_ready=1; it is a registered-state decode, not a combinational path from rsp_ready.
  - On req_valid && req_ready: register adr/we/dat/sel onto the it_* outputs, set it_cyc=it_stb=1, clear the counter, go to BUS.
  - it_cyc rises the cycle after acceptance.
- BUS:
  - req_ready=0. Hold it_* stable.
  - Each cycle without ack/err, the counter increments.
  - it_ack sampled 1:
    - drop it_cyc/it_stb next edge;
    - rsp_dat = it_dat_r on a read, 0 on a write;
    - rsp_err=0, rsp_timeout=0, rsp_valid=1; go to RSP.
  - it_err sampled 1 (also when ack and err are both 1): drop cyc/stb; rsp_dat=0, rsp_err=1, rsp_timeout=0; go to RSP.
  - TIMEOUT!=0 and counter==TIMEOUT-1 with no ack/err: drop cyc/stb; rsp_err=1, rsp_timeout=1, rsp_dat=0; go to RSP.
    - The first cycle of BUS counts as 1, so a timeout occurs after exactly TIMEOUT bus cycles.
  - An ack arriving on the timeout cycle wins (normal response).
- RSP:
  - req_ready=0; rsp_valid=1; rsp fields held stable.
  - On rsp_ready: rsp_valid=0 next edge, go to IDLE.
  - Minimum spacing: accept@N, cyc@N+1, ack@N+1, rsp_valid@N+2; rsp_ready@N+2 gives req_ready@N+3.
- it_ack/it_err outside BUS are ignored; no response is produced.
- Reset mid-operation (any state): immediate return to reset values next edge.
  - Any pending response is discarded.
  - The cycle is abandoned by deasserting it_cyc.
- Counter width is clog2(TIMEOUT+1), saturating; no wrap.
- it_cyc==it_stb at all times (no burst, no stall-hold of stb without cyc).

Test Plan:
- Write: req adr=0x4, dat=0xDEADBEEF, sel=0xF, we=1; target acks one cycle after stb -> it_* match for exactly 1 cycle; rsp_valid with rsp_err=0, rsp_dat=0.
- Read with wait states: adr=0x8, target acks after 3 cycles with it_dat_r=0x12345678 -> cyc held 4 cycles stable; rsp_dat=0x12345678, rsp_err=0.
- Error: target asserts it_err, also with ack and err together -> rsp_err=1, rsp_timeout=0, rsp_dat=0.
- Timeout, TIMEOUT=4, target silent -> cyc high exactly 4 cycles; rsp_err=1, rsp_timeout=1. Repeat with ack on the 4th cycle -> normal response.
- Backpressure: rsp_ready low 5 cycles -> rsp held stable, req_ready=0, a second req_valid not accepted; after rsp_ready, the second request is accepted 1 cycle later.
- Synchronous reset asserted in BUS and in RSP -> next edge it_cyc=0, rsp_valid=0, req_ready=1; a late ack after reset produces no response.
